// File: rtl/core_pkg.sv
// Shared core constants: register-file geometry and the forwarding-select encoding
// used by the execute-stage operand muxes.
package core_pkg;

  localparam int REG_ADDR_W = 3;

  localparam logic [REG_ADDR_W-1:0] R0 = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage to hazard-unit bundle. Statistics counters exist only when
// HAZARD_STATS_EN is defined.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  ex_branch_taken;

  logic [1:0]            forwardA;
  logic [1:0]            forwardB;
  logic                  stall;
  logic                  id_ex_bubble;
  logic                  flush_if_id;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken,
`ifdef HAZARD_STATS_EN
    input  stall_count, flush_count,
`endif
    input  forwardA, forwardB, stall, id_ex_bubble, flush_if_id
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken,
`ifdef HAZARD_STATS_EN
    output stall_count, flush_count,
`endif
    output forwardA, forwardB, stall, id_ex_bubble, flush_if_id
  );

endinterface

// File: rtl/fwd_select.sv
// Compares one ID source register against the EX/MEM and MEM/WB shadows and
// returns the operand select; the younger (EX/MEM) producer takes priority.
module fwd_select
  import core_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              i_src_en,
  input  logic [ADDR_W-1:0] i_src,
  input  logic              i_ex_valid,
  input  logic              i_ex_reg_write,
  input  logic [ADDR_W-1:0] i_ex_rd,
  input  logic              i_mem_valid,
  input  logic              i_mem_reg_write,
  input  logic [ADDR_W-1:0] i_mem_rd,
  output fwd_sel_e          o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_ex_hit  = i_src_en && i_ex_valid && i_ex_reg_write &&
                (i_ex_rd != '0) && (i_src == i_ex_rd);
    w_mem_hit = i_src_en && i_mem_valid && i_mem_reg_write &&
                (i_mem_rd != '0) && (i_src == i_mem_rd);
    o_sel     = FWD_REG;
    if (w_ex_hit) begin
      o_sel = FWD_MEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Execute-stage forwarding, load-use stall and taken-branch flush control.
// Define HAZARD_STATS_EN to add saturating stall/flush counters.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic                clk,
  input logic                rst,
  hazard_forward_unit_if.slave bus
);

  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_reg_write;
  logic                  r_ex_mem_read;
  logic                  r_ex_valid;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_reg_write;
  logic                  r_mem_valid;

  core_pkg::fwd_sel_e    r_fwd_a;
  core_pkg::fwd_sel_e    r_fwd_b;
  core_pkg::fwd_sel_e    w_sel_a;
  core_pkg::fwd_sel_e    w_sel_b;

  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_bubble;

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_src_en        (bus.id_valid),
    .i_src           (bus.id_rs1),
    .i_ex_valid      (r_ex_valid),
    .i_ex_reg_write  (r_ex_reg_write),
    .i_ex_rd         (r_ex_rd),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_rd        (r_mem_rd),
    .o_sel           (w_sel_a)
  );

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_src_en        (bus.id_valid && bus.id_uses_rs2),
    .i_src           (bus.id_rs2),
    .i_ex_valid      (r_ex_valid),
    .i_ex_reg_write  (r_ex_reg_write),
    .i_ex_rd         (r_ex_rd),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_rd        (r_mem_rd),
    .o_sel           (w_sel_b)
  );

  // A load in EX cannot supply its data until MEM, so a dependent ID instruction waits.
  assign w_load_use = bus.id_valid && r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) &&
                      ((bus.id_rs1 == r_ex_rd) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == r_ex_rd)));

  // A taken branch squashes the ID instruction anyway, so it overrides the stall.
  assign w_stall  = w_load_use && !bus.ex_branch_taken;
  assign w_bubble = w_stall || bus.ex_branch_taken;

  assign bus.stall        = w_stall;
  assign bus.id_ex_bubble = w_bubble;
  assign bus.flush_if_id  = bus.ex_branch_taken;
  assign bus.forwardA     = r_fwd_a;
  assign bus.forwardB     = r_fwd_b;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_valid      <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_fwd_a         <= core_pkg::FWD_REG;
      r_fwd_b         <= core_pkg::FWD_REG;
    end else begin
      r_mem_rd        <= r_ex_rd;
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_valid     <= r_ex_valid;
      r_ex_rd         <= bus.id_rd;
      r_ex_reg_write  <= bus.id_reg_write;
      r_ex_mem_read   <= bus.id_mem_read;
      r_ex_valid      <= bus.id_valid && !w_bubble;
      if (w_bubble) begin
        r_fwd_a <= core_pkg::FWD_REG;
        r_fwd_b <= core_pkg::FWD_REG;
      end else begin
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (bus.ex_branch_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a driver pushes expected responses
// from an in-flight-instruction model, a negedge monitor pops and compares.
module tb_hazard_forward_unit;
  import core_pkg::*;

  localparam int AW = core_pkg::REG_ADDR_W;
  localparam int CW = 16;

  typedef struct {
    bit             v;
    bit             rw;
    bit             mr;
    logic [AW-1:0]  rd;
  } slot_t;

  typedef struct {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
    int         sc;
    int         fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_ADDR_W(AW)) bus ();

  hazard_forward_unit #(.REG_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       exp_q[$];
  slot_t      inflight[$];   // [0] = instruction now in EX, [1] = now in MEM
  logic [1:0] cur_fa;
  logic [1:0] cur_fb;
  int         m_stalls;
  int         m_flushes;
  bit         last_stall;
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic clear_model();
    slot_t empty;
    empty = '{v: 1'b0, rw: 1'b0, mr: 1'b0, rd: '0};
    inflight.delete();
    inflight.push_back(empty);
    inflight.push_back(empty);
    cur_fa    = 2'b00;
    cur_fb    = 2'b00;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // Youngest older writer of src decides: one ahead -> ALU result in MEM, two ahead -> WB.
  function automatic logic [1:0] producer_sel(input logic [AW-1:0] src, input bit en);
    if (!en || src == '0) return FWD_REG;
    for (int age = 0; age < 2; age++) begin
      if (inflight[age].v && inflight[age].rw && inflight[age].rd == src)
        return (age == 0) ? FWD_MEM : FWD_WB;
    end
    return FWD_REG;
  endfunction

  task automatic issue(input bit v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input bit u2, input logic [AW-1:0] rd, input bit rw, input bit mr,
                       input bit br, input bit hold_rst, input bit rst_mid);
    exp_t  e;
    slot_t s;
    bit    ld_use;
    @(posedge clk);
    #2;
    rst                 = hold_rst;
    bus.id_valid        = v;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_uses_rs2     = u2;
    bus.id_rd           = rd;
    bus.id_reg_write    = rw;
    bus.id_mem_read     = mr;
    bus.ex_branch_taken = br;
    if (hold_rst) clear_model();
    ld_use = v && inflight[0].v && inflight[0].mr && inflight[0].rd != '0 &&
             (rs1 == inflight[0].rd || (u2 && rs2 == inflight[0].rd));
    e.stall  = ld_use && !br;
    e.flush  = br;
    e.bubble = e.stall || br;
    e.fa     = cur_fa;
    e.fb     = cur_fb;
    e.sc     = m_stalls;
    e.fc     = m_flushes;
    exp_q.push_back(e);
    last_stall = e.stall;
    if (hold_rst) begin
      clear_model();
    end else if (rst_mid) begin
      @(negedge clk);
      #1;
      rst = 1'b1;
      clear_model();
    end else begin
      cur_fa = e.bubble ? 2'b00 : producer_sel(rs1, v);
      cur_fb = e.bubble ? 2'b00 : producer_sel(rs2, v && u2);
      s = '{v: v && !e.bubble, rw: rw, mr: mr, rd: rd};
      inflight.push_front(s);
      void'(inflight.pop_back());
      if (e.stall && m_stalls < (1 << CW) - 1) m_stalls++;
      if (e.flush && m_flushes < (1 << CW) - 1) m_flushes++;
    end
  endtask

  task automatic nop();
    issue(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall", 32'(bus.stall), 32'(e.stall));
      check("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e.bubble));
      check("flush_if_id", 32'(bus.flush_if_id), 32'(e.flush));
      check("forwardA", 32'(bus.forwardA), 32'(e.fa));
      check("forwardB", 32'(bus.forwardB), 32'(e.fb));
`ifdef HAZARD_STATS_EN
      check("stall_count", 32'(bus.stall_count), e.sc);
      check("flush_count", 32'(bus.flush_count), e.fc);
`endif
    end
  end

  bit            p_v, p_u2, p_rw, p_mr;
  logic [AW-1:0] p_rs1, p_rs2, p_rd;

  initial begin
    rst                 = 1'b1;
    bus.id_valid        = 1'b0;
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_uses_rs2     = 1'b0;
    bus.id_rd           = '0;
    bus.id_reg_write    = 1'b0;
    bus.id_mem_read     = 1'b0;
    bus.ex_branch_taken = 1'b0;
    clear_model();
    last_stall = 1'b0;

    for (int i = 0; i < 3; i++) issue(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ADD r1 ; ADD r2,r1,r3
    issue(1'b1, 3'd2, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // ADD r1 ; NOP ; SUB r4,r1,r1
    issue(1'b1, 3'd2, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    issue(1'b1, 3'd1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // LD r5 ; ADD r6,r5,r0 (stalls once, then re-presented)
    issue(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd5, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd5, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // ADD r2 ; ADDI r2,r7,imm with r2 in the ignored rs2 field
    issue(1'b1, 3'd1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd7, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // LD r3 in EX, taken branch while ID reads r3
    issue(1'b1, 3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd3, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nop(); nop();
    // Fresh reset, three load-use stalls, then reset asserted mid-stall
    issue(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 3'd5, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 3'd5, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    nop();
    issue(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'd5, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 3'd5, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();

    // Random traffic; a stalled ID instruction is re-presented unchanged
    last_stall = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        p_v   = ($urandom_range(9) != 0);
        p_rs1 = AW'($urandom_range(7));
        p_rs2 = AW'($urandom_range(7));
        p_u2  = ($urandom_range(1) != 0);
        p_rd  = AW'($urandom_range(7));
        p_rw  = ($urandom_range(4) != 0);
        p_mr  = ($urandom_range(2) == 0);
      end
      issue(p_v, p_rs1, p_rs2, p_u2, p_rd, p_rw, p_mr,
            ($urandom_range(9) == 0), ($urandom_range(299) == 0), ($urandom_range(399) == 0));
    end
    nop();

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected responses never compared", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
